// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default baud divisor, FSM encoding.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int DEF_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/uart_tx_8n1_if.sv
// Byte-level handshake between the upstream test stage and the UART transmitter.
interface uart_tx_8n1_if;

  logic       i_tx_dv;
  logic [7:0] i_tx_byte;
  logic       o_tx_serial;
  logic       o_tx_active;
  logic       o_tx_done;

  // upstream stage: raises a request, watches done
  modport master (
    output i_tx_dv, i_tx_byte,
    input  o_tx_serial, o_tx_active, o_tx_done
  );

  // transmitter side
  modport slave (
    input  i_tx_dv, i_tx_byte,
    output o_tx_serial, o_tx_active, o_tx_done
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last count.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = uart_pkg::DEF_CLKS_PER_BIT,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_W'(CLKS_PER_BIT - 1));

  // wrap on each bit boundary; clear takes priority so the count is 0 outside a frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit; registered outputs.
module uart_tx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_W        = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_8n1_if.slave   bus
);

  state_t     state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic       dv_q;
  logic       serial_q, serial_d;
  logic       active_q, active_d;
  logic       done_q, done_d;
  logic       baud_en, tick;

  // counter only runs while a bit is on the line
  assign baud_en = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .en    (baud_en),
    .clr   (!baud_en),
    .tick  (tick)
  );

  // next state plus next-cycle line values; outputs are taken from the next state so they
  // flip exactly on the bit boundary and never glitch
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    case (state_q)
      ST_IDLE: begin
        bit_d = '0;
        // rising edge only: a level held since reset or across DONE does not retrigger
        if (bus.i_tx_dv && !dv_q) begin
          state_d = ST_START;
          shreg_d = bus.i_tx_byte;
        end
      end
      ST_START: begin
        bit_d = '0;
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
          else                            bit_d   = bit_q + 1'b1;
        end
      end
      ST_STOP: if (tick) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    serial_d = 1'b1;
    active_d = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      ST_START: begin serial_d = 1'b0;           active_d = 1'b1; end
      ST_DATA:  begin serial_d = shreg_d[bit_d]; active_d = 1'b1; end
      ST_STOP:  active_d = 1'b1;
      ST_DONE:  done_d   = 1'b1;
      default:  ;
    endcase
  end

  // state, datapath and registered outputs; reset drops the line back to idle immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      shreg_q  <= '0;
      dv_q     <= 1'b1;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      dv_q     <= bus.i_tx_dv;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign bus.o_tx_serial = serial_q;
  assign bus.o_tx_active = active_q;
  assign bus.o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Bench for uart_tx_8n1: two instances (4 and 434 clocks per bit) checked every cycle
// against a frame-timeline model driven only by the bench's own stimulus.
module tb_uart_tx_8n1;

  localparam int CPB0 = 4;
  localparam int CPB1 = 434;

  logic       clk = 1'b0;
  logic [1:0] rst_n;
  logic [1:0] dv;
  logic [7:0] tx_byte [2];
  logic [1:0] ser, act, dn;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_8n1_if bus0 ();
  uart_tx_8n1_if bus1 ();

  assign bus0.i_tx_dv   = dv[0];
  assign bus0.i_tx_byte = tx_byte[0];
  assign bus1.i_tx_dv   = dv[1];
  assign bus1.i_tx_byte = tx_byte[1];
  assign ser = {bus1.o_tx_serial, bus0.o_tx_serial};
  assign act = {bus1.o_tx_active, bus0.o_tx_active};
  assign dn  = {bus1.o_tx_done,   bus0.o_tx_done};

  uart_tx_8n1 #(.CLKS_PER_BIT(CPB0), .CNT_W(16)) u0 (.clk(clk), .reset(rst_n[0]), .bus(bus0.slave));
  uart_tx_8n1 #(.CLKS_PER_BIT(CPB1), .CNT_W(16)) u1 (.clk(clk), .reset(rst_n[1]), .bus(bus1.slave));

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int cpb(int i);
    return (i == 0) ? CPB0 : CPB1;
  endfunction

  // expected {serial, active, done} t cycles after the start cycle of a frame carrying b
  function automatic logic [2:0] frame_out(int t, logic [7:0] b, int c);
    int k;
    logic s;
    if (t >= 1 && t <= 10 * c) begin
      k = (t - 1) / c;                  // 0 = start bit, 1..8 = data, 9 = stop
      if (k == 0)      s = 1'b0;
      else if (k <= 8) s = b[k-1];
      else             s = 1'b1;
      return {s, 1'b1, 1'b0};
    end
    if (t == 10 * c + 1) return 3'b101;
    return 3'b100;
  endfunction

  // model: per-instance frame start cycle, latched byte, previous request level
  int         m_start [2];
  bit         m_act   [2];
  logic [7:0] m_byte  [2];
  bit         m_prev  [2];
  int         m_done  [2];
  int         o_done  [2];

  // inputs change just after posedge, so mid-cycle sampling sees one coherent cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [2:0] e;
      int         t;
      bit         busy;
      t    = cyc - m_start[i];
      busy = m_act[i] && (t <= 10 * cpb(i) + 1);
      if (!rst_n[i]) begin
        e         = 3'b100;
        m_act[i]  = 1'b0;
        m_prev[i] = 1'b1;
      end else begin
        e = busy ? frame_out(t, m_byte[i], cpb(i)) : 3'b100;
      end
      check($sformatf("serial[%0d]", i), 32'(ser[i]), 32'(e[2]));
      check($sformatf("active[%0d]", i), 32'(act[i]), 32'(e[1]));
      check($sformatf("done[%0d]", i),   32'(dn[i]),  32'(e[0]));
      if (e[0])  m_done[i]++;
      if (dn[i]) o_done[i]++;
      if (rst_n[i]) begin
        if (!busy && dv[i] && !m_prev[i]) begin
          m_start[i] = cyc;
          m_byte[i]  = tx_byte[i];
          m_act[i]   = 1'b1;
        end
        m_prev[i] = dv[i];
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(int i, logic [7:0] b);
    dv[i] = 1'b1;
    tx_byte[i] = b;
    step(1);
    dv[i] = 1'b0;
  endtask

  // start a 0x0F frame, hit reset inside data bit 3, then send 0x19 cleanly
  task automatic reset_mid_frame(int i);
    int c;
    c = cpb(i);
    send(i, 8'h0F);
    step(4 * c + 1);                    // now inside bit 3 (t = 4c+2)
    rst_n[i] = 1'b0;
    #1;
    check($sformatf("rst_serial[%0d]", i), 32'(ser[i]), 32'd1);
    check($sformatf("rst_active[%0d]", i), 32'(act[i]), 32'd0);
    step(1);
    rst_n[i] = 1'b1;
    step(2);
    send(i, 8'h19);
    step(10 * c + 4);
  endtask

  initial begin
    rst_n = 2'b00;
    dv = 2'b00;
    tx_byte[0] = 8'h00;
    tx_byte[1] = 8'h00;
    step(3);
    rst_n = 2'b11;
    step(20);

    send(0, 8'h55);  step(45);
    send(0, 8'h00);  step(44);
    send(0, 8'hFF);  step(44);

    // request held through done and a few cycles beyond
    dv[0] = 1'b1;
    tx_byte[0] = 8'($urandom);
    step(10 * CPB0 + 6);
    dv[0] = 1'b0;
    step(3);

    // second rising edge mid-DATA with a new byte must be ignored
    send(0, 8'h3C);
    step(13);
    dv[0] = 1'b1;
    tx_byte[0] = 8'hA3;
    step(2);
    dv[0] = 1'b0;
    step(30);

    reset_mid_frame(0);

    // random requests: random hold lengths and gaps, byte churn while busy
    repeat (12) begin
      int hold;
      hold = $urandom_range(1, 45);
      dv[0] = 1'b1;
      tx_byte[0] = 8'($urandom);
      repeat (hold) begin
        step(1);
        tx_byte[0] = 8'($urandom);
      end
      dv[0] = 1'b0;
      step($urandom_range(1, 3));
    end
    step(10 * CPB0 + 5);

    reset_mid_frame(1);

    check("done_pulses[0]", 32'(o_done[0]), 32'(m_done[0]));
    check("done_pulses[1]", 32'(o_done[1]), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
